// File: rtl/coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : coeff_loader
// Description : Scatters a linear coefficient stream across N memory banks.
//               Word i is written to bank (i mod N) at address (i div N),
//               one registered write per accepted word, ROWS rows per transfer.
// Revision    : 1.0  initial release
// ============================================================================
module coeff_loader #(
    parameter int N      = 257,
    parameter int ROWS   = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic [N-1:0]          mem_we,
    output logic [N*ADDR_W-1:0]   mem_addr,
    output logic [N*DATA_W-1:0]   mem_din
);

    // Counter widths; a single bank or single row still needs one bit.
    localparam int BANK_W = (N > 1)    ? $clog2(N)    : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [BANK_W-1:0] c_last_bank = BANK_W'(N - 1);
    localparam logic [ROW_W-1:0]  c_last_row  = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [BANK_W-1:0]   r_bank;
    logic [ROW_W-1:0]    r_row;
    logic                w_ready;
    logic                w_busy;
    logic                w_done;
    logic                w_accept;
    logic                w_last;
    logic [N-1:0]        r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_din;

    assign w_accept = in_valid && w_ready;
    assign w_last   = (r_bank == c_last_bank) && (r_row == c_last_row);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake/status decode. DONE coincides with the
    // registered write of the final word, so done and the last mem_we align.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (in_valid && w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Bank/row counters: cleared when a transfer starts, advanced per
    // accepted word, frozen on the final word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank <= '0;
            r_row  <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_bank <= '0;
            r_row  <= '0;
        end else if (w_accept && !w_last) begin
            if (r_bank == c_last_bank) begin
                r_bank <= '0;
                r_row  <= r_row + ROW_W'(1);
            end else begin
                r_bank <= r_bank + BANK_W'(1);
            end
        end
    end

    // Write port: one-hot enable for one cycle after each acceptance;
    // address and data are shared by all lanes and hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= '0;
            r_addr <= '0;
            r_din  <= '0;
        end else begin
            r_we <= w_accept ? (N'(1) << r_bank) : '0;
            if (w_accept) begin
                r_addr <= ADDR_W'(r_row);
                r_din  <= in_data;
            end
        end
    end

    assign in_ready = w_ready;
    assign busy     = w_busy;
    assign done     = w_done;
    assign mem_we   = r_we;
    assign mem_addr = {N{r_addr}};
    assign mem_din  = {N{r_din}};

endmodule
`default_nettype wire
